rgb_to_color_code: RTL and testbench
====================================

# rgb_to_color_code

Iterative nearest-palette quantizer that maps an 8-bit RGB332 pixel back to the 3-bit background color code. It is the inverse of the background palette lookup. It sits between sprite/bitmap sources and logic that needs a palette index, such as collision-by-color and background repaint. The block searches the 8 palette entries sequentially under a valid/ready handshake and returns the closest code and its distance.

## Interface
- G_SHIFT, default 0: left shift applied to the green absolute difference (perceptual weight). Legal range is 0..2.
- clk  input  1  system clock
- resetN  input  1  asynchronous, active-low reset
- RGBin  input  8  pixel, RGB332: R=[7:5], G=[4:2], B=[1:0]
- in_valid  input  1  RGBin is valid
- in_ready  output  1  block can accept a pixel
- colorCode  output  3  nearest palette code
- distance  output  6  weighted distance of the winning entry
- out_valid  output  1  colorCode and distance are valid
- out_ready  input  1  consumer accepts the result

## Operation
- Palette, fixed as code: RGB:
  - 000: CC
  - 001: 59
  - 010: DA
  - 011: 5B
  - 100: 4D
  - 101: 78
  - 110: D8
  - 111: EE
- Distance formula: d = |Rp−Rc| + (|Gp−Gc| << G_SHIFT) + |Bp−Bc|.
  - Each field difference is unsigned.
  - Sum is computed at 6 bits; the maximum is 38, so there is no overflow.
- FSM states: IDLE, SEARCH, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch RGBin, set idx=0, best_d=63, best_code=0, go to SEARCH.
- SEARCH:
  - Each cycle, evaluate entry idx.
  - If d < best_d (strictly less), update best_d and best_code. Ties therefore keep the lowest code.
  - idx increments 0→7. After idx=7 is evaluated, go to DONE. idx never wraps into a second pass.
- DONE:
  - out_valid=1; colorCode=best_code; distance=best_d, all held stable.
  - On out_valid && out_ready, go to IDLE.
- in_ready=0 in SEARCH and DONE. in_valid is ignored there, and RGBin changes do not affect the latched pixel.
- colorCode and distance are registered. They keep their last value after the handshake until the next result.

## Timing
- Reset values while resetN=0: in_ready=0, out_valid=0, colorCode=0, distance=0, state=IDLE.
- in_ready is registered. It rises on the first clk edge after resetN deasserts.
- Latency: accept at edge E0; entries are evaluated at E1..E8; out_valid is high after E8. That is 8 cycles from accept to result.
- Result handshake:
  - Handshake at edge Ek means out_valid=0 and in_ready=1 after Ek.
  - The next accept is at Ek+1 at the earliest. Throughput is one pixel per 10 cycles with no stalls.
- out_ready held low: DONE persists indefinitely, with outputs stable.
- out_ready held high: DONE lasts exactly 1 cycle.
- Reset asserted mid-SEARCH or mid-DONE: outputs go immediately to reset values and the pixel in flight is discarded.

## Configuration
- COLOR_EXACT_EARLY_EN
  - Defined: in SEARCH, if d==0 at entry idx=k, go to DONE at that edge with best_code=k and distance=0. out_valid then rises k+1 cycles after accept.
  - Undefined: all 8 entries are always scanned, giving a fixed 8-cycle latency. Results are identical in both builds; only latency differs.

## Test plan
- Reset, release, then apply RGBin=0xDA with out_ready=1 → colorCode=010, distance=0. out_valid is 8 cycles after accept, or 3 cycles with COLOR_EXACT_EARLY_EN.
- RGBin=0x00, G_SHIFT=0 → colorCode=100, distance=6. RGBin=0xFF → colorCode=010, distance=3.
- Tie: RGBin=0x5A (codes 001 and 011 both at distance 1) → colorCode=001, distance=1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → outputs stable, in_ready=0. A changing RGBin/in_valid has no effect. Release → out_valid drops and in_ready=1 next cycle.
- Early exit: with COLOR_EXACT_EARLY_EN defined, RGBin=0xCC → colorCode=000, distance=0, out_valid 1 cycle after accept. With the macro undefined → same result at 8 cycles.
- Mid-search reset: assert resetN=0 four cycles after accepting 0xEE → all outputs 0 immediately. After release, 0xEE re-sent → colorCode=111, distance=0.

Source files
------------

// File: rtl/rgb_to_color_code.sv
// rgb_to_color_code: sequential nearest-palette search mapping an RGB332 pixel to its 3-bit background code.
// Optional COLOR_EXACT_EARLY_EN stops the scan on the first exact (zero-distance) palette match.
module rgb_to_color_code #(
    parameter int G_SHIFT = 0
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] RGBin,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] colorCode,
    output logic [5:0] distance,
    output logic       out_valid,
    input  logic       out_ready
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic [7:0] PALETTE [8] = '{8'hCC, 8'h59, 8'hDA, 8'h5B, 8'h4D, 8'h78, 8'hD8, 8'hEE};

    state_t     state_q, state_d;
    logic       in_ready_q, in_ready_d;
    logic [7:0] pix_q, pix_d;
    logic [2:0] idx_q, idx_d;
    logic [5:0] best_d_q, best_d_d;
    logic [2:0] best_code_q, best_code_d;
    logic [2:0] code_q, code_d;
    logic [5:0] dist_q, dist_d;

    logic [7:0] pal;
    logic [2:0] dr, dg;
    logic [1:0] db;
    logic [5:0] d_cur, nb_d;
    logic [2:0] nb_code;
    logic       better, last;

    assign pal     = PALETTE[idx_q];
    assign dr      = (pix_q[7:5] > pal[7:5]) ? pix_q[7:5] - pal[7:5] : pal[7:5] - pix_q[7:5];
    assign dg      = (pix_q[4:2] > pal[4:2]) ? pix_q[4:2] - pal[4:2] : pal[4:2] - pix_q[4:2];
    assign db      = (pix_q[1:0] > pal[1:0]) ? pix_q[1:0] - pal[1:0] : pal[1:0] - pix_q[1:0];
    assign d_cur   = {3'b000, dr} + ({3'b000, dg} << G_SHIFT) + {4'b0000, db};
    // strict compare keeps the lowest code on ties
    assign better  = d_cur < best_d_q;
    assign nb_d    = better ? d_cur : best_d_q;
    assign nb_code = better ? idx_q : best_code_q;
`ifdef COLOR_EXACT_EARLY_EN
    assign last    = (idx_q == 3'd7) || (d_cur == 6'd0);
`else
    assign last    = (idx_q == 3'd7);
`endif

    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        idx_d       = idx_q;
        best_d_d    = best_d_q;
        best_code_d = best_code_q;
        code_d      = code_q;
        dist_d      = dist_q;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                pix_d       = RGBin;
                idx_d       = 3'd0;
                best_d_d    = 6'd63;
                best_code_d = 3'd0;
                state_d     = SEARCH;
            end
            SEARCH: begin
                best_d_d    = nb_d;
                best_code_d = nb_code;
                idx_d       = idx_q + 3'd1;
                if (last) begin
                    state_d = DONE;
                    code_d  = nb_code;
                    dist_d  = nb_d;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            pix_q       <= 8'h00;
            idx_q       <= 3'd0;
            best_d_q    <= 6'd63;
            best_code_q <= 3'd0;
            code_q      <= 3'd0;
            dist_q      <= 6'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            pix_q       <= pix_d;
            idx_q       <= idx_d;
            best_d_q    <= best_d_d;
            best_code_q <= best_code_d;
            code_q      <= code_d;
            dist_q      <= dist_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DONE);
    assign colorCode = code_q;
    assign distance  = dist_q;
endmodule

// File: tb/tb_rgb_to_color_code.sv
// tb_rgb_to_color_code: directed vectors checked against a brute-force nearest-palette model.
module tb_rgb_to_color_code;
    localparam int GS = 0;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [7:0] RGBin = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid;
    logic [2:0] colorCode;
    logic [5:0] distance;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] exp_code = 3'd0;
    logic [5:0] exp_dist = 6'd0;

    rgb_to_color_code #(.G_SHIFT(GS)) dut (
        .clk(clk), .resetN(resetN), .RGBin(RGBin), .in_valid(in_valid), .in_ready(in_ready),
        .colorCode(colorCode), .distance(distance), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // brute force over the palette: {code, distance}
    function automatic logic [8:0] nearest(input logic [7:0] p);
        int pal [8] = '{'hCC, 'h59, 'hDA, 'h5B, 'h4D, 'h78, 'hD8, 'hEE};
        int best = 1000;
        int code = 0;
        for (int c = 0; c < 8; c++) begin
            int dr = (int'(p) >> 5) - (pal[c] >> 5);
            int dg = ((int'(p) >> 2) & 7) - ((pal[c] >> 2) & 7);
            int db = (int'(p) & 3) - (pal[c] & 3);
            int d;
            d = (dr < 0 ? -dr : dr) + ((dg < 0 ? -dg : dg) << GS) + (db < 0 ? -db : db);
            if (d < best) begin
                best = d;
                code = c;
            end
        end
        return {code[2:0], best[5:0]};
    endfunction

    always @(negedge clk) begin
        if (resetN === 1'b1 && out_valid === 1'b1) begin
            chk("result_code", colorCode, exp_code);
            chk("result_dist", distance, exp_dist);
        end
        if (resetN === 1'b1 && out_valid === 1'b1 && in_ready === 1'b1)
            chk("ready_valid_exclusive", 1, 0);
    end

    task automatic send(input logic [7:0] p, input int hold);
        int n = 0;
        int lat = 0;
        int exp_lat;
        logic [8:0] m;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", in_ready, 1);
        m = nearest(p);
        exp_code = m[8:6];
        exp_dist = m[5:0];
        exp_lat = 8;
`ifdef COLOR_EXACT_EARLY_EN
        if (m[5:0] == 6'd0) exp_lat = int'(m[8:6]) + 1;
`endif
        RGBin = p;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        RGBin = 8'($urandom);
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            RGBin = 8'($urandom);
            lat++;
        end
        chk("latency", lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_code", colorCode, exp_code);
            chk("hold_dist", distance, exp_dist);
            RGBin = 8'($urandom);
            in_valid = 1'($urandom);
        end
        if (hold > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [8:0] m;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_code", colorCode, 0);
        chk("rst_dist", distance, 0);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        chk("release_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        chk("release_in_ready_high", in_ready, 1);

        m = nearest(8'h00); chk("model_00", m, {3'd4, 6'd6});
        m = nearest(8'hFF); chk("model_ff", m, {3'd2, 6'd3});
        m = nearest(8'h5A); chk("model_5a", m, {3'd1, 6'd1});
        m = nearest(8'hDA); chk("model_da", m, {3'd2, 6'd0});

        send(8'hDA, 0); chk("da_code", colorCode, 2); chk("da_dist", distance, 0);
        send(8'h00, 0); chk("00_code", colorCode, 4); chk("00_dist", distance, 6);
        send(8'hFF, 0); chk("ff_code", colorCode, 2); chk("ff_dist", distance, 3);
        send(8'hCC, 0); chk("cc_code", colorCode, 0); chk("cc_dist", distance, 0);
        send(8'h5A, 20); chk("5a_code", colorCode, 1); chk("5a_dist", distance, 1);
        send(8'h93, 0);
        send(8'h5A, 0);

        @(negedge clk);
        exp_code = 3'd7;
        exp_dist = 6'd0;
        RGBin = 8'hEE;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        resetN = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_code", colorCode, 0);
        chk("midrst_dist", distance, 0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        send(8'hEE, 0); chk("ee_code", colorCode, 7); chk("ee_dist", distance, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
